chain_core_relax: RTL and testbench
===================================

# chain_core_relax

Parametrised rope-simulation core holding `NODES` consecutive chain nodes with `W`-bit signed fixed-point coordinates. It replaces the per-node constraint instances and free-running circular control token with one shared relaxation unit. That unit is swept over the nodes under a start/done handshake, for `ITER` Gauss-Seidel passes per frame. Cores are chained: each one exchanges its boundary node positions with its neighbours, the first core pins its head, and the last core's tail tracks the mouse.

## Interface
- `NODES`, 5, nodes in this core (≥1)
- `W`, 32, coordinate width, signed two's complement
- `ITER`, 4, relaxation passes per frame (≥1)
- `CORE_ID`, 1, position of the core in the chain; `CORE_ID==1` pins the head node
- `SPACING`, 16, initial x pitch between nodes
- `GRAVITY`, 1, per-pass y decrement; used only with the macro
- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: synchronous, active-high
- `start` in 1: request one frame; sampled only in IDLE
- `is_last` in 1: this core owns the chain tail (mouse-driven)
- `prev_x`, `prev_y` in W each: last node of previous core
- `next_x`, `next_y` in W each: first node of next core
- `x_mouse`, `y_mouse` in W each: mouse target
- `busy` out 1: high during SWEEP
- `done` out 1: one-cycle pulse at frame end
- `nodes_x`, `nodes_y` out NODES*W each: node k at bits [(k+1)*W-1 : k*W]

## Operation
- **Reset values:**
  - node k: x = (k + (CORE_ID-1)*NODES)*SPACING, y = 0
  - FSM in IDLE, `busy` = 0, `done` = 0
- **FSM states:** IDLE, SWEEP, DONE.
  - IDLE & `start` → SWEEP. Latch `prev_*`, `next_*`, `x_mouse`, `y_mouse`, `is_last`. Set idx = 0, pass = 0.
  - SWEEP: update node idx at each edge.
    - idx = NODES-1 and pass = ITER-1 → DONE.
    - idx = NODES-1 otherwise → idx = 0, pass++.
    - Otherwise idx++.
  - DONE → IDLE unconditionally.
- **Per-node update, each axis independently:** new = (p + 2·c + n) >>> 2.
  - Sum computed at W+2 bits; arithmetic shift rounds toward −∞; result truncated to W bits.
  - p is node idx-1, or latched prev for idx 0. n is node idx+1, or latched next for idx NODES-1.
  - Gauss-Seidel: node idx-1 already holds this pass's value; node idx+1 holds its pre-update value.
- **Anchors:**
  - Head node 0 with `CORE_ID==1`: held, never updated.
  - Tail node NODES-1 with latched `is_last`: loaded directly with the latched mouse position.
  - If both apply (NODES==1), the mouse wins.
- Inputs changing during SWEEP have no effect; only latched copies are used.
- `start` in SWEEP or DONE is ignored, not queued.

## Timing
- `start` sampled high in IDLE at cycle t. SWEEP occupies cycles t+1 … t+NODES·ITER, with `busy` = 1.
- `done` = 1 in cycle t+NODES·ITER+1 only. The earliest next accept is cycle t+NODES·ITER+2.
- `nodes_*` are registered. The update of node idx is visible in the cycle after its SWEEP cycle.
- Reset asserted mid-SWEEP: at the next edge, all nodes return to initial positions and the FSM returns to IDLE. No `done` is issued.
- `reset` and `start` high together: reset wins.

## Configuration
- `CHAIN_CORE_GRAVITY_EN` defined: after each relax of a non-anchor node, y ← y − GRAVITY.
  - Saturates at the most negative W-bit value.
  - Anchored nodes are unaffected.
- Macro undefined: no gravity term; `GRAVITY` is ignored and no subtractor is built.

## Structure
- `chain_pkg` holds:
  - FSM state enum
  - coordinate typedef parametrised by W
  - initial-position function (k, CORE_ID, NODES, SPACING)
- Sub-module `chain_relax`: combinational single-axis (p + 2c + n) >>> 2 with W+2 internal width.
  - Instantiated twice, once for x and once for y.
  - The gravity subtract stays in the core.

## Test plan
Defaults unless stated (NODES=5, ITER=4, CORE_ID=1).
- **Reset:** assert reset for 2 cycles.
  - → `nodes_x` = {0,16,32,48,64}, all y = 0, `busy` = 0, `done` = 0.
- **Straight chain:** `is_last`=0, next=(80,0), start at t.
  - → positions unchanged; `busy` high t+1…t+20; `done` only at t+21.
- **Mouse tail, ITER=1:** `is_last`=1, mouse=(64,100).
  - First frame → node4 y = 100, others y = 0.
  - Second frame → node3 y = (0+0+100)>>>2 = 25.
- **Start ignored while busy:** hold `start` high throughout.
  - → exactly one `done` pulse per NODES·ITER+2 cycles; no overlap.
- **Reset mid-frame:** reset at 7th SWEEP cycle.
  - → next cycle `busy` = 0, `done` = 0, positions at initial values.
- **Gravity, macro defined:** GRAVITY=1, ITER=1, `is_last`=0, next=(80,0).
  - → y = {0,−1,−2,−2,−2}.
  - Macro undefined → all y = 0.

Source files
------------

// File: rtl/chain_core_relax_pkg.sv
// Shared types and helpers for the chain relaxation core.
//   state_e  : frame FSM states
//   coord_t  : signed coordinate at the default width
//   init_x() : reset x position of node k of a given core
package chain_core_relax_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int unsigned COORD_W = 32;
  typedef logic signed [COORD_W-1:0] coord_t;

  // Chain-global node index times pitch; callers truncate to their coordinate width.
  function automatic longint init_x(input int unsigned k, input int unsigned core_id,
                                    input int unsigned nodes, input int unsigned spacing);
    return (longint'(k) + (longint'(core_id) - 64'sd1) * longint'(nodes)) * longint'(spacing);
  endfunction

endpackage

// File: rtl/chain_core_relax_if.sv
// Frame handshake, boundary/mouse inputs and packed node outputs of one core.
//   master : drives start/is_last/prev/next/mouse, observes busy/done/nodes
//   slave  : the core side
interface chain_core_relax_if #(
  parameter int unsigned NODES = 5,
  parameter int unsigned W     = 32
);
  logic                  start;
  logic                  is_last;
  logic signed [W-1:0]   prev_x;
  logic signed [W-1:0]   prev_y;
  logic signed [W-1:0]   next_x;
  logic signed [W-1:0]   next_y;
  logic signed [W-1:0]   x_mouse;
  logic signed [W-1:0]   y_mouse;
  logic                  busy;
  logic                  done;
  logic [NODES*W-1:0]    nodes_x;
  logic [NODES*W-1:0]    nodes_y;

  modport master (
    output start, is_last, prev_x, prev_y, next_x, next_y, x_mouse, y_mouse,
    input  busy, done, nodes_x, nodes_y
  );

  modport slave (
    input  start, is_last, prev_x, prev_y, next_x, next_y, x_mouse, y_mouse,
    output busy, done, nodes_x, nodes_y
  );
endinterface

// File: rtl/chain_core_relax_relax.sv
// Single-axis relaxation: r = (p + 2c + n) >>> 2, summed at W+2 bits and
// floored by the arithmetic shift, then truncated back to W bits.
//   p, c, n : previous, current, next coordinate
//   r       : relaxed coordinate
module chain_core_relax_relax #(
  parameter int unsigned W = 32
) (
  input  logic signed [W-1:0] p,
  input  logic signed [W-1:0] c,
  input  logic signed [W-1:0] n,
  output logic signed [W-1:0] r
);
  logic signed [W+1:0] sum;

  always_comb begin
    sum = (W+2)'(p) + ((W+2)'(c) <<< 1) + (W+2)'(n);
    r   = W'(sum >>> 2);
  end
endmodule

// File: rtl/chain_core_relax.sv
// Rope-chain core: NODES nodes relaxed by one shared unit, swept ITER
// Gauss-Seidel passes per frame under a start/done handshake.
//   clk, reset : clock, synchronous active-high reset
//   bus        : chain_core_relax_if slave (start/busy/done, boundaries, mouse, nodes)
// Optional: define CHAIN_CORE_GRAVITY_EN to subtract GRAVITY (saturating) from
// the y of every relaxed non-anchor node.
module chain_core_relax
  import chain_core_relax_pkg::*;
#(
  parameter int unsigned NODES   = 5,
  parameter int unsigned W       = 32,
  parameter int unsigned ITER    = 4,
  parameter int unsigned CORE_ID = 1,
  parameter int unsigned SPACING = 16,
  parameter int unsigned GRAVITY = 1
) (
  input logic              clk,
  input logic              reset,
  chain_core_relax_if.slave bus
);
  localparam int unsigned IDX_W  = (NODES > 1) ? $clog2(NODES) : 1;
  localparam int unsigned PASS_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NODES - 1);
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(ITER - 1);
  localparam bit PIN_HEAD = (CORE_ID == 1);

  state_e              state;
  logic [IDX_W-1:0]    idx;
  logic [PASS_W-1:0]   pass;
  logic                busy_q;
  logic                done_q;
  logic                last_l;
  logic signed [W-1:0] prev_x_l, prev_y_l, next_x_l, next_y_l, mouse_x_l, mouse_y_l;
  logic signed [W-1:0] x_q [NODES];
  logic signed [W-1:0] y_q [NODES];

  logic [IDX_W-1:0]    idx_p, idx_n;
  logic signed [W-1:0] p_x, p_y, n_x, n_y, c_x, c_y, rx, ry, y_upd;

  // Neighbour selection: latched boundary values stand in past either end.
  always_comb begin
    idx_p = (idx == '0) ? idx : idx - 1'b1;
    idx_n = (idx == LAST_IDX) ? idx : idx + 1'b1;
    c_x   = x_q[idx];
    c_y   = y_q[idx];
    p_x   = (idx == '0) ? prev_x_l : x_q[idx_p];
    p_y   = (idx == '0) ? prev_y_l : y_q[idx_p];
    n_x   = (idx == LAST_IDX) ? next_x_l : x_q[idx_n];
    n_y   = (idx == LAST_IDX) ? next_y_l : y_q[idx_n];
  end

  chain_core_relax_relax #(.W(W)) u_relax_x (.p(p_x), .c(c_x), .n(n_x), .r(rx));
  chain_core_relax_relax #(.W(W)) u_relax_y (.p(p_y), .c(c_y), .n(n_y), .r(ry));

`ifdef CHAIN_CORE_GRAVITY_EN
  logic [W:0] y_diff;

  // One extra bit exposes overflow; clamp instead of wrapping.
  always_comb begin
    y_diff = {ry[W-1], ry} - (W+1)'(GRAVITY);
    if (y_diff[W] != y_diff[W-1]) begin
      y_upd = y_diff[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      y_upd = y_diff[W-1:0];
    end
  end
`else
  assign y_upd = ry;
`endif

  // Frame FSM, counters, input latches and node storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      pass      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      last_l    <= 1'b0;
      prev_x_l  <= '0;
      prev_y_l  <= '0;
      next_x_l  <= '0;
      next_y_l  <= '0;
      mouse_x_l <= '0;
      mouse_y_l <= '0;
      for (int k = 0; k < int'(NODES); k++) begin
        x_q[k] <= W'(init_x(k, CORE_ID, NODES, SPACING));
        y_q[k] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            last_l    <= bus.is_last;
            prev_x_l  <= bus.prev_x;
            prev_y_l  <= bus.prev_y;
            next_x_l  <= bus.next_x;
            next_y_l  <= bus.next_y;
            mouse_x_l <= bus.x_mouse;
            mouse_y_l <= bus.y_mouse;
            idx       <= '0;
            pass      <= '0;
            busy_q    <= 1'b1;
            state     <= ST_SWEEP;
          end
        end
        ST_SWEEP: begin
          // Mouse tail takes priority over the pinned head when NODES==1.
          if (last_l && (idx == LAST_IDX)) begin
            x_q[idx] <= mouse_x_l;
            y_q[idx] <= mouse_y_l;
          end else if (!(PIN_HEAD && (idx == '0))) begin
            x_q[idx] <= rx;
            y_q[idx] <= y_upd;
          end
          if (idx == LAST_IDX) begin
            idx <= '0;
            if (pass == LAST_PASS) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= ST_DONE;
            end else begin
              pass <= pass + 1'b1;
            end
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          done_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Pack registered node storage onto the output buses.
  always_comb begin
    bus.nodes_x = '0;
    bus.nodes_y = '0;
    for (int k = 0; k < int'(NODES); k++) begin
      bus.nodes_x[k*W +: W] = x_q[k];
      bus.nodes_y[k*W +: W] = y_q[k];
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_chain_core_relax.sv
// Self-checking bench for chain_core_relax: one ITER=4 core and one ITER=1 core,
// both CORE_ID=1, checked against a floor-division reference model.
module tb_chain_core_relax;
  localparam int N    = 5;
  localparam int W    = 32;
  localparam int GRAV = 1;

  typedef longint arr_t [N];

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  chain_core_relax_if #(.NODES(N), .W(W)) if4 ();
  chain_core_relax_if #(.NODES(N), .W(W)) if1 ();

  chain_core_relax #(.NODES(N), .W(W), .ITER(4), .CORE_ID(1), .SPACING(16), .GRAVITY(GRAV))
    dut4 (.clk(clk), .reset(reset), .bus(if4.slave));
  chain_core_relax #(.NODES(N), .W(W), .ITER(1), .CORE_ID(1), .SPACING(16), .GRAVITY(GRAV))
    dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

  int   checks = 0;
  int   passed = 0;
  arr_t mx4, my4, mx1, my1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint coord(input logic [N*W-1:0] v, input int k);
    return longint'($signed(v[k*W +: W]));
  endfunction

  function automatic longint rnd();
    return longint'($urandom_range(2000)) - 64'sd1000;
  endfunction

  task automatic model_init(output arr_t x, output arr_t y);
    for (int k = 0; k < N; k++) begin
      x[k] = 16 * k;
      y[k] = 0;
    end
  endtask

  // Reference frame: ITER sweeps, head pinned, tail optionally glued to mouse.
  task automatic model_frame(input int iter, input bit last,
                             input longint px, input longint py, input longint nx, input longint ny,
                             input longint msx, input longint msy,
                             input arr_t xi, input arr_t yi, output arr_t xo, output arr_t yo);
    longint pvx, pvy, nvx, nvy;
    xo = xi;
    yo = yi;
    for (int p = 0; p < iter; p++) begin
      for (int k = 0; k < N; k++) begin
        if (last && k == N - 1) begin
          xo[k] = msx;
          yo[k] = msy;
        end else if (k != 0) begin
          pvx = xo[k-1];
          pvy = yo[k-1];
          nvx = (k == N - 1) ? nx : xo[k+1];
          nvy = (k == N - 1) ? ny : yo[k+1];
          xo[k] = (pvx + 2 * xo[k] + nvx) >>> 2;
          yo[k] = (pvy + 2 * yo[k] + nvy) >>> 2;
`ifdef CHAIN_CORE_GRAVITY_EN
          yo[k] = yo[k] - GRAV;
          if (yo[k] < -(64'sd1 <<< (W - 1))) yo[k] = -(64'sd1 <<< (W - 1));
`endif
        end
      end
    end
    if (px == 0 && py == 0) begin end
  endtask

  task automatic drive(input bit sel, input bit last, input longint px, input longint py,
                       input longint nx, input longint ny, input longint msx, input longint msy);
    if (sel) begin
      if1.is_last = last; if1.prev_x = 32'(px); if1.prev_y = 32'(py);
      if1.next_x = 32'(nx); if1.next_y = 32'(ny); if1.x_mouse = 32'(msx); if1.y_mouse = 32'(msy);
    end else begin
      if4.is_last = last; if4.prev_x = 32'(px); if4.prev_y = 32'(py);
      if4.next_x = 32'(nx); if4.next_y = 32'(ny); if4.x_mouse = 32'(msx); if4.y_mouse = 32'(msy);
    end
  endtask

  // Runs one frame on the chosen core (sel=1: ITER=1 core) and advances its model.
  task automatic frame(input bit sel, input bit last, input longint px, input longint py,
                       input longint nx, input longint ny, input longint msx, input longint msy,
                       input bit scramble);
    int cnt;
    bit seen;
    drive(sel, last, px, py, nx, ny, msx, msy);
    if (sel) if1.start = 1'b1; else if4.start = 1'b1;
    step();
    if1.start = 1'b0;
    if4.start = 1'b0;
    cnt  = 0;
    seen = 1'b0;
    while (!seen && cnt < 100) begin
      if (scramble) drive(sel, $urandom_range(1) == 1, rnd(), rnd(), rnd(), rnd(), rnd(), rnd());
      seen = sel ? if1.done : if4.done;
      if (!seen) begin
        step();
        cnt++;
      end
    end
    checks++;
    if (!seen) $display("FAIL frame_done_timeout: got no done after %0d cycles, required done", cnt);
    else passed++;
    step();
    if (sel) model_frame(1, last, px, py, nx, ny, msx, msy, mx1, my1, mx1, my1);
    else     model_frame(4, last, px, py, nx, ny, msx, msy, mx4, my4, mx4, my4);
  endtask

  task automatic test_reset();
    logic [N*W-1:0] vx, vy;
    reset = 1'b1;
    step();
    step();
    vx = if4.nodes_x;
    vy = if4.nodes_y;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (coord(vx, k) !== 16 * k) $display("FAIL reset_x[%0d]: got %0d, required %0d", k, coord(vx, k), 16 * k);
      else passed++;
      checks++;
      if (coord(vy, k) !== 0) $display("FAIL reset_y[%0d]: got %0d, required 0", k, coord(vy, k));
      else passed++;
    end
    checks++;
    if (if4.busy !== 1'b0 || if1.busy !== 1'b0) $display("FAIL reset_busy: got %b/%b, required 0/0", if4.busy, if1.busy);
    else passed++;
    checks++;
    if (if4.done !== 1'b0 || if1.done !== 1'b0) $display("FAIL reset_done: got %b/%b, required 0/0", if4.done, if1.done);
    else passed++;
    reset = 1'b0;
    model_init(mx4, my4);
    model_init(mx1, my1);
  endtask

  task automatic test_straight_chain();
    logic [N*W-1:0] vx, vy;
    drive(1'b0, 1'b0, -16, 0, 80, 0, 500, 500);
    if4.start = 1'b1;
    step();
    if4.start = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      checks++;
      if (if4.busy !== (c <= 20)) $display("FAIL straight_busy@t+%0d: got %b, required %b", c, if4.busy, (c <= 20));
      else passed++;
      checks++;
      if (if4.done !== (c == 21)) $display("FAIL straight_done@t+%0d: got %b, required %b", c, if4.done, (c == 21));
      else passed++;
      step();
    end
    model_frame(4, 1'b0, -16, 0, 80, 0, 500, 500, mx4, my4, mx4, my4);
    vx = if4.nodes_x;
    vy = if4.nodes_y;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (coord(vx, k) !== mx4[k]) $display("FAIL straight_x[%0d]: got %0d, required %0d", k, coord(vx, k), mx4[k]);
      else passed++;
      checks++;
      if (coord(vy, k) !== my4[k]) $display("FAIL straight_y[%0d]: got %0d, required %0d", k, coord(vy, k), my4[k]);
      else passed++;
    end
  endtask

  task automatic test_gravity();
    logic [N*W-1:0] vy;
    longint         exp_y [N];
`ifdef CHAIN_CORE_GRAVITY_EN
    exp_y = '{0, -1, -2, -2, -2};
`else
    exp_y = '{0, 0, 0, 0, 0};
`endif
    frame(1'b1, 1'b0, -16, 0, 80, 0, 0, 0, 1'b0);
    vy = if1.nodes_y;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (coord(vy, k) !== exp_y[k]) $display("FAIL gravity_y[%0d]: got %0d, required %0d", k, coord(vy, k), exp_y[k]);
      else passed++;
    end
  endtask

  task automatic test_mouse_tail();
    logic [N*W-1:0] vx, vy;
    for (int f = 0; f < 2; f++) begin
      frame(1'b1, 1'b1, -16, 0, 80, 0, 64, 100, 1'b0);
      vx = if1.nodes_x;
      vy = if1.nodes_y;
      for (int k = 0; k < N; k++) begin
        checks++;
        if (coord(vx, k) !== mx1[k]) $display("FAIL mouse_x[f%0d][%0d]: got %0d, required %0d", f, k, coord(vx, k), mx1[k]);
        else passed++;
        checks++;
        if (coord(vy, k) !== my1[k]) $display("FAIL mouse_y[f%0d][%0d]: got %0d, required %0d", f, k, coord(vy, k), my1[k]);
        else passed++;
      end
      checks++;
      if (coord(vy, 4) !== 100) $display("FAIL mouse_tail_y[f%0d]: got %0d, required 100", f, coord(vy, 4));
      else passed++;
`ifndef CHAIN_CORE_GRAVITY_EN
      if (f == 1) begin
        checks++;
        if (coord(vy, 3) !== 25) $display("FAIL mouse_node3_y: got %0d, required 25", coord(vy, 3));
        else passed++;
      end
`endif
    end
  endtask

  task automatic test_random_frames();
    logic [N*W-1:0] vx, vy;
    for (int f = 0; f < 4; f++) begin
      frame(1'b0, $urandom_range(1) == 1, rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), 1'b1);
      vx = if4.nodes_x;
      vy = if4.nodes_y;
      for (int k = 0; k < N; k++) begin
        checks++;
        if (coord(vx, k) !== mx4[k]) $display("FAIL random_x[f%0d][%0d]: got %0d, required %0d", f, k, coord(vx, k), mx4[k]);
        else passed++;
        checks++;
        if (coord(vy, k) !== my4[k]) $display("FAIL random_y[f%0d][%0d]: got %0d, required %0d", f, k, coord(vy, k), my4[k]);
        else passed++;
      end
    end
  endtask

  task automatic test_start_held();
    logic [N*W-1:0] vx, vy;
    longint px, py, nx, ny, msx, msy;
    bit     last, eb, ed;
    px = rnd(); py = rnd(); nx = rnd(); ny = rnd(); msx = rnd(); msy = rnd();
    last = $urandom_range(1) == 1;
    drive(1'b0, last, px, py, nx, ny, msx, msy);
    if4.start = 1'b1;
    step();
    for (int c = 1; c <= 66; c++) begin
      eb = ((c % 22) >= 1) && ((c % 22) <= 20);
      ed = (c >= 21) && (((c - 21) % 22) == 0);
      checks++;
      if (if4.busy !== eb) $display("FAIL held_busy@t+%0d: got %b, required %b", c, if4.busy, eb);
      else passed++;
      checks++;
      if (if4.done !== ed) $display("FAIL held_done@t+%0d: got %b, required %b", c, if4.done, ed);
      else passed++;
      if (c == 65) if4.start = 1'b0;
      step();
    end
    for (int f = 0; f < 3; f++) model_frame(4, last, px, py, nx, ny, msx, msy, mx4, my4, mx4, my4);
    vx = if4.nodes_x;
    vy = if4.nodes_y;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (coord(vx, k) !== mx4[k] || coord(vy, k) !== my4[k])
        $display("FAIL held_node[%0d]: got (%0d,%0d), required (%0d,%0d)", k, coord(vx, k), coord(vy, k), mx4[k], my4[k]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [N*W-1:0] vx, vy;
    int             pulses;
    drive(1'b0, 1'b1, rnd(), rnd(), rnd(), rnd(), rnd(), rnd());
    if4.start = 1'b1;
    step();
    if4.start = 1'b0;
    for (int c = 1; c < 7; c++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_init(mx4, my4);
    model_init(mx1, my1);
    checks++;
    if (if4.busy !== 1'b0) $display("FAIL midreset_busy: got %b, required 0", if4.busy);
    else passed++;
    checks++;
    if (if4.done !== 1'b0) $display("FAIL midreset_done: got %b, required 0", if4.done);
    else passed++;
    vx = if4.nodes_x;
    vy = if4.nodes_y;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (coord(vx, k) !== mx4[k] || coord(vy, k) !== my4[k])
        $display("FAIL midreset_node[%0d]: got (%0d,%0d), required (%0d,%0d)", k, coord(vx, k), coord(vy, k), mx4[k], my4[k]);
      else passed++;
    end
    pulses = 0;
    for (int c = 0; c < 25; c++) begin
      if (if4.done === 1'b1 || if4.busy === 1'b1) pulses++;
      step();
    end
    checks++;
    if (pulses != 0) $display("FAIL midreset_activity: got %0d active cycles, required 0", pulses);
    else passed++;
    reset     = 1'b1;
    if4.start = 1'b1;
    step();
    reset     = 1'b0;
    if4.start = 1'b0;
    checks++;
    if (if4.busy !== 1'b0) $display("FAIL reset_vs_start_busy: got %b, required 0", if4.busy);
    else passed++;
    step();
    checks++;
    if (if4.busy !== 1'b0) $display("FAIL reset_vs_start_queued: got %b, required 0", if4.busy);
    else passed++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    if4.start = 1'b0;
    if1.start = 1'b0;
    drive(1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
    drive(1'b1, 1'b0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_straight_chain();
    test_gravity();
    test_mouse_tail();
    test_random_frames();
    test_start_held();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
